// File: rtl/cache_pkg.sv
// Shared types for the load channel arbiter: requester ids, FSM states, bus widths.
package cache_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  // Owner id of an outstanding load: 0 = instruction cache, 1 = data cache.
  typedef logic requester_id_t;

  localparam requester_id_t ReqIcache = 1'b0;
  localparam requester_id_t ReqDcache = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLockM0 = 2'd1,
    StLockM1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/load_channel_arbiter_if.sv
// Requester, memory and status signals of the load channel arbiter.
// slave: the arbiter side; master: the requester/memory environment side.
interface load_channel_arbiter_if;
  import cache_pkg::*;

  logic                 m0_request_i;
  logic [AddrWidth-1:0] m0_address_i;
  logic                 m0_invalidate_i;
  logic                 m0_grant_o;
  logic [DataWidth-1:0] m0_data_o;
  logic                 m0_valid_o;

  logic                 m1_request_i;
  logic [AddrWidth-1:0] m1_address_i;
  logic                 m1_invalidate_i;
  logic                 m1_grant_o;
  logic [DataWidth-1:0] m1_data_o;
  logic                 m1_valid_o;

  logic                 mem_request_o;
  logic [AddrWidth-1:0] mem_address_o;
  logic                 mem_invalidate_o;
  logic [DataWidth-1:0] mem_data_i;
  logic                 mem_valid_i;

  logic                 error_o;

  modport slave (
    input  m0_request_i, m0_address_i, m0_invalidate_i,
    input  m1_request_i, m1_address_i, m1_invalidate_i,
    input  mem_data_i, mem_valid_i,
    output m0_grant_o, m0_data_o, m0_valid_o,
    output m1_grant_o, m1_data_o, m1_valid_o,
    output mem_request_o, mem_address_o, mem_invalidate_o, error_o
  );

  modport master (
    output m0_request_i, m0_address_i, m0_invalidate_i,
    output m1_request_i, m1_address_i, m1_invalidate_i,
    output mem_data_i, mem_valid_i,
    input  m0_grant_o, m0_data_o, m0_valid_o,
    input  m1_grant_o, m1_data_o, m1_valid_o,
    input  mem_request_o, mem_address_o, mem_invalidate_o, error_o
  );

endinterface

// File: rtl/owner_fifo.sv
// FIFO of owner ids for outstanding loads; memory responses return in order,
// so the head names the requester of the next response.
module owner_fifo import cache_pkg::*; #(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  requester_id_t id_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output requester_id_t head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] owner_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = requester_id_t'(owner_q[rd_ptr_q]);

  // Storage, wrapping pointers and occupancy; flush drops every entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        owner_q[wr_ptr_q] <= id_i;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/load_channel_arbiter.sv
// Arbitrates the instruction- and data-cache load requests onto one memory load
// channel with zero-latency grants, burst locking and in-order response routing.
// Optional macro LOAD_ARBITER_ROUND_ROBIN_EN: round-robin winner selection in
// IDLE; without it the data cache (m1) has fixed priority.
module load_channel_arbiter import cache_pkg::*; #(
  parameter int unsigned BURST = 4,
  parameter int unsigned DEPTH = 8
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  load_channel_arbiter_if.slave bus
);

  localparam int unsigned BurstW = $clog2(BURST) + 1;

  arb_state_t        state_q;
  logic [BurstW-1:0] burst_count_q;
  logic [1:0]        req;
  logic              invalidate;
  logic              grant_any;
  logic              release_lock;
  requester_id_t     grant_id;
  requester_id_t     idle_winner;
  requester_id_t     head_id;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign req        = {bus.m1_request_i, bus.m0_request_i};
  assign invalidate = bus.m0_invalidate_i | bus.m1_invalidate_i;

`ifdef LOAD_ARBITER_ROUND_ROBIN_EN
  requester_id_t rr_q;

  // Round-robin pick when both request; a lone requester always wins.
  always_comb begin
    if (req[0] && req[1]) begin
      idle_winner = rr_q;
    end else begin
      idle_winner = req[1] ? ReqDcache : ReqIcache;
    end
  end

  // Pointer moves to the other requester whenever a lock is released.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q <= ReqIcache;
    end else if (release_lock && !invalidate) begin
      rr_q <= ~grant_id;
    end
  end
`else
  assign idle_winner = req[1] ? ReqDcache : ReqIcache;
`endif

  // Grant decision for the current cycle; full FIFO or invalidate blocks it.
  always_comb begin
    grant_any    = 1'b0;
    grant_id     = idle_winner;
    release_lock = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_any = |req;
      end
      StLockM0, StLockM1: begin
        grant_id = (state_q == StLockM1) ? ReqDcache : ReqIcache;
        if (burst_count_q == BurstW'(BURST) || !req[grant_id]) begin
          release_lock = 1'b1;
        end else begin
          grant_any = 1'b1;
        end
      end
      default: ;
    endcase
    if (invalidate || fifo_full || !rst_n_i) begin
      grant_any = 1'b0;
    end
  end

  // Arbitration FSM with burst counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      burst_count_q <= '0;
    end else if (invalidate || release_lock) begin
      state_q       <= StIdle;
      burst_count_q <= '0;
    end else if (grant_any) begin
      if (state_q == StIdle) begin
        state_q       <= grant_id ? StLockM1 : StLockM0;
        burst_count_q <= BurstW'(1);
      end else begin
        burst_count_q <= burst_count_q + BurstW'(1);
      end
    end
  end

  // Responses arriving during an invalidate are discarded with the flush.
  assign pop = bus.mem_valid_i & ~fifo_empty & ~invalidate;

  owner_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (grant_any),
    .id_i   (grant_id),
    .pop_i  (pop),
    .flush_i(invalidate),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head_id)
  );

  // Output drive; everything held at zero while reset is asserted.
  always_comb begin
    bus.m0_grant_o       = 1'b0;
    bus.m1_grant_o       = 1'b0;
    bus.m0_valid_o       = 1'b0;
    bus.m1_valid_o       = 1'b0;
    bus.m0_data_o        = '0;
    bus.m1_data_o        = '0;
    bus.mem_request_o    = 1'b0;
    bus.mem_address_o    = '0;
    bus.mem_invalidate_o = 1'b0;
    bus.error_o          = 1'b0;
    if (rst_n_i) begin
      bus.mem_invalidate_o = invalidate;
      bus.error_o          = bus.mem_valid_i & fifo_empty;
      if (grant_any) begin
        bus.mem_request_o = 1'b1;
        if (grant_id == ReqDcache) begin
          bus.m1_grant_o    = 1'b1;
          bus.mem_address_o = bus.m1_address_i;
        end else begin
          bus.m0_grant_o    = 1'b1;
          bus.mem_address_o = bus.m0_address_i;
        end
      end
      if (pop) begin
        if (head_id == ReqDcache) begin
          bus.m1_valid_o = 1'b1;
          bus.m1_data_o  = bus.mem_data_i;
        end else begin
          bus.m0_valid_o = 1'b1;
          bus.m0_data_o  = bus.mem_data_i;
        end
      end
    end
  end

endmodule

// File: doc/load_channel_arbiter.md
LOAD_CHANNEL_ARBITER -- requirements
Module: load_channel_arbiter

Interface
REQ-001 The block SHALL have parameter BURST, default 4, giving the maximum number of words forwarded per grant (power of two, at least 1).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of outstanding-request owner FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk_i  in  1  clock; reset rst_n_i, asynchronous, active-low.
REQ-004 The block SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports mN_request_i  in  1  and mN_address_i  in  32, per requester N in {0 = instruction cache, 1 = data cache}: load request and word address.
REQ-006 The block SHALL have port mN_invalidate_i  in  1  per requester N: flush request.
REQ-007 The block SHALL have port mN_grant_o  out  1  per requester N: request accepted this cycle.
REQ-008 The block SHALL have ports mN_data_o  out  32  and mN_valid_o  out  1  per requester N: routed response.
REQ-009 The block SHALL have ports mem_request_o  out  1,  mem_address_o  out  32  and  mem_invalidate_o  out  1: memory load channel command.
REQ-010 The block SHALL have ports mem_data_i  in  32  and  mem_valid_i  in  1: in-order memory response.
REQ-011 The block SHALL have port error_o  out  1: one-cycle pulse on an orphan response.

Function
REQ-012 A requester SHALL hold mN_request_i and mN_address_i stable until it sees mN_grant_o high in the same cycle.
REQ-013 The grant SHALL be zero-latency: in a granted cycle, mem_request_o = 1 and mem_address_o = the winner's address, combinationally.
REQ-014 The FSM SHALL have states IDLE, LOCK_M0 and LOCK_M1.
REQ-015 In IDLE, the block SHALL pick a winner among the active requests, grant it, and go to LOCK_Mn with burst_count = 1.
REQ-016 In LOCK_Mn, only requester n SHALL be grantable; each grant increments burst_count.
REQ-017 The FSM SHALL return to IDLE when burst_count reaches BURST or when mn_request_i is low in a LOCK_Mn cycle; that cycle issues no grant.
REQ-018 Each grant SHALL push the owner id into the FIFO.
REQ-019 While the FIFO is full, the block SHALL issue no grant and drive mem_request_o = 0; a same-cycle pop SHALL NOT unblock that cycle.
REQ-020 On mem_valid_i, the block SHALL pop the FIFO head and, in the same cycle, assert mOwner_valid_o with mOwner_data_o = mem_data_i; the non-owner data SHALL be 0.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-022 If mem_valid_i arrives with the FIFO empty, the block SHALL drop it, assert no valid, and pulse error_o.
REQ-023 Any mN_invalidate_i SHALL force mem_invalidate_o = 1 and clear the FIFO and burst_count on the next edge; the FSM SHALL go to IDLE, and that cycle issues no grant.
REQ-024 During invalidate, responses of both requesters SHALL be discarded; both requesters SHALL reissue.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL use clog2(DEPTH)+1 bits.

Reset
REQ-026 On reset, the FSM SHALL be in IDLE with FIFO empty, burst_count = 0 and round-robin pointer = 0.
REQ-027 During reset, all outputs SHALL be 0.
REQ-028 A reset asserted mid-burst SHALL abandon all outstanding ownership, with no responses routed afterwards.

Configuration
REQ-029 With LOAD_ARBITER_ROUND_ROBIN_EN defined, the IDLE winner SHALL be chosen by round-robin: the pointer moves to the other requester after each lock release.
REQ-030 Without LOAD_ARBITER_ROUND_ROBIN_EN, the IDLE winner SHALL be fixed priority, with m1 (data cache) winning over m0.

Structure
REQ-031 The owner id type (requester_id_t, 1 bit) and the FSM state enum SHALL live in cache_pkg.
REQ-032 The owner FIFO SHALL be a sub-module, owner_fifo, with push, pop, flush, full, empty and head ports.

Verification
REQ-033 The bench SHALL cover: m1 requests 4 words at 0x100..0x10C with m0 idle -> 4 consecutive grants, addresses in order, return to IDLE after the 4th, FIFO count = 4.
REQ-034 The bench SHALL cover: m0 and m1 request together, round-robin build -> m0 burst first, then m1; fixed build -> m1 first.
REQ-035 The bench SHALL cover: DEPTH = 8 with 8 grants and no responses -> 9th request has grant = 0 and mem_request_o = 0; one mem_valid_i -> grant the next cycle.
REQ-036 The bench SHALL cover: outstanding owners [m1, m0, m1] with responses 0xA, 0xB, 0xC -> m1 gets 0xA, m0 gets 0xB, m1 gets 0xC, each in the arrival cycle.
REQ-037 The bench SHALL cover: m1 invalidate with 3 outstanding -> mem_invalidate_o = 1, FIFO empty next cycle, a later mem_valid_i pulses error_o.
REQ-038 The bench SHALL cover: reset asserted mid-burst -> all outputs 0 immediately; after release the FSM is in IDLE and the FIFO is empty.
